// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for a shared 8:1 data mux. A grant lasts at most BURST_MAX beats.
// The selected lane is registered onto dout, and dout_valid qualifies each beat.
module mux8_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          req,
  input  logic [8*DATA_W-1:0] din,
  output logic [7:0]          gnt,
  output logic [2:0]          sel,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_valid,
  output logic                busy
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t              state_q, state_d;
  logic [7:0]          gnt_q, gnt_d;
  logic [2:0]          sel_q, sel_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          ptr_q, ptr_d;

  logic [DATA_W-1:0]   lane [8];
  logic [2:0]          arb_from;
  logic [2:0]          scan_idx;
  logic                pick_vld;
  logic [2:0]          pick_idx;
  logic [CNT_W-1:0]    cnt_inc;

  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign lane[i] = din[i*DATA_W +: DATA_W];
  end

  // While granted, the next winner is searched starting just past the current owner,
  // so the owner is the last one considered and only wins again if nobody else is asking.
  always_comb begin
    arb_from = (state_q == ST_GRANT) ? sel_q + 3'd1 : ptr_q;
    pick_vld = 1'b0;
    pick_idx = arb_from;
    scan_idx = arb_from;
    for (int k = 7; k >= 0; k--) begin
      scan_idx = arb_from + 3'(k);
      if (req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  // dout_valid is a plain valid strobe with no backpressure. dout carries a fresh beat
  // exactly on the cycles where dout_valid is 1, and it holds its value otherwise.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    sel_d        = sel_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d = 8'h00;
        if (pick_vld) begin
          state_d = ST_GRANT;
          gnt_d   = 8'b1 << pick_idx;
          sel_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (req[sel_q]) begin
          dout_d       = lane[sel_q];
          dout_valid_d = 1'b1;
          if (cnt_inc == CNT_W'(BURST_MAX)) begin
            ptr_d = sel_q + 3'd1;
            gnt_d = 8'b1 << pick_idx;
            sel_d = pick_idx;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          ptr_d = sel_q + 3'd1;
          cnt_d = '0;
          if (pick_vld) begin
            gnt_d = 8'b1 << pick_idx;
            sel_d = pick_idx;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 8'h00;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 8'h00;
      sel_q        <= 3'd0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      cnt_q        <= '0;
      ptr_q        <= 3'd0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      sel_q        <= sel_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
    end
  end

  assign gnt        = gnt_q;
  assign sel        = sel_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q == ST_GRANT);

endmodule
